// File: rtl/keypad_pkg.sv
// ============================================================================
// keypad_pkg : shared constants, state encoding and key-code table for the
//              4x4 keypad scanner.  Rev 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] COL_FIRST  = 4'b1110;

  // Nibble (r*4 + c) holds the code for row r, column c.
  localparam logic [63:0] KEY_TABLE = 64'hDF0E_C987_B654_A321;

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) idx = i[1:0];
    end
    return idx;
  endfunction

  function automatic logic one_low(input logic [3:0] v);
    return ($countones(~v) == 1);
  endfunction

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    return KEY_TABLE[{r, c, 2'b00} +: 4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scan_if.sv
// ============================================================================
// keypad_scan_if : keypad matrix and display-digit bus of the scanner.
//                  Rev 1.0
// ============================================================================
`default_nettype none

interface keypad_scan_if;
  import keypad_pkg::*;

  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] C;

  modport master (
    input  row,
    output col, key_code, key_valid, A, B, C
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, A, B, C
  );
endinterface

`default_nettype wire

// File: rtl/keypad_debounce.sv
// ============================================================================
// keypad_debounce : debounce sample counter and candidate-key compare.
//                   Rev 1.0
// ============================================================================
`default_nettype none

module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       inc,
  input  logic       clr,
  input  logic [3:0] code,
  input  logic [3:0] cand,
  output logic       same,
  output logic       full
);

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CNT - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = 4'd0;
    else if (load) cnt_d = 4'd1;
    else if (inc)  cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  // The sample being evaluated is the one that would bring the count to DEBOUNCE_CNT.
  assign full = (cnt_q == DEB_LAST);
  assign same = (code == cand);

endmodule

`default_nettype wire

// File: rtl/keypad_scan.sv
// ============================================================================
// keypad_scan : 4x4 matrix keypad scanner with debounce, ghost rejection and
//               a three-digit display history.  Rev 1.0
// ============================================================================
`default_nettype none

module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C
);

  localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

  logic [3:0]  sync1_q, sync2_q;
  logic [15:0] presc_q, presc_d;
  state_t      state_q, state_d;
  logic [3:0]  col_q, col_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  a_q, a_d, b_q, b_d, c_q, c_d;

  logic        scan_tick;
  logic        hit;
  logic [3:0]  hit_code;
  logic        deb_load, deb_inc, deb_clr;
  logic        deb_same, deb_full;

  assign scan_tick = (presc_q == PRESC_LAST);
  assign presc_d   = scan_tick ? 16'd0 : presc_q + 16'd1;
  assign hit       = one_low(sync2_q);
  assign hit_code  = key_lookup(low_index(sync2_q), low_index(col_q));

  keypad_debounce #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (deb_load),
    .inc   (deb_inc),
    .clr   (deb_clr),
    .code  (hit_code),
    .cand  (cand_q),
    .same  (deb_same),
    .full  (deb_full)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    deb_load    = 1'b0;
    deb_inc     = 1'b0;
    deb_clr     = 1'b0;

    if (scan_tick) begin
      case (state_q)
        ST_SCAN: begin
          if (hit) begin
            cand_d   = hit_code;
            deb_load = 1'b1;
            state_d  = ST_DEB_PRESS;
          end else begin
            col_d = {col_q[2:0], col_q[3]};
          end
        end
        ST_DEB_PRESS: begin
          if (hit && deb_same) begin
            if (deb_full) begin
              state_d     = ST_HELD;
              deb_clr     = 1'b1;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              c_d         = b_q;
              b_d         = a_q;
              a_d         = cand_q;
            end else begin
              deb_inc = 1'b1;
            end
          end else begin
            // Column stays put so the next tick re-examines the same column.
            state_d = ST_SCAN;
            deb_clr = 1'b1;
          end
        end
        ST_HELD: begin
          if (!hit) begin
            state_d  = ST_DEB_RELEASE;
            deb_load = 1'b1;
          end
        end
        ST_DEB_RELEASE: begin
          if (hit) begin
            state_d = ST_HELD;
            deb_clr = 1'b1;
          end else if (deb_full) begin
            state_d = ST_SCAN;
            deb_clr = 1'b1;
            col_d   = {col_q[2:0], col_q[3]};
          end else begin
            deb_inc = 1'b1;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      presc_q     <= 16'd0;
      state_q     <= ST_SCAN;
      col_q       <= COL_FIRST;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      a_q         <= BLANK_CODE;
      b_q         <= BLANK_CODE;
      c_q         <= BLANK_CODE;
    end else begin
      sync1_q     <= row;
      sync2_q     <= sync1_q;
      presc_q     <= presc_d;
      state_q     <= state_d;
      col_q       <= col_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign C         = c_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
// ============================================================================
// tb_keypad_scan : physical-keypad model driving keypad_scan, with a
//                  scoreboard of expected accepted keys.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  typedef struct packed {
    logic [3:0] code;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_scan_if kbus ();

  // Keypad matrix: a pressed switch at (r,c) pulls row r low while column c is driven low.
  logic [15:0] pressed = 16'h0;
  logic [3:0]  row_drv;
  always_comb begin
    row_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kbus.col[c]) row_drv[r] = 1'b0;
  end
  assign kbus.row = row_drv;

  keypad_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (kbus.row),
    .col       (kbus.col),
    .key_code  (kbus.key_code),
    .key_valid (kbus.key_valid),
    .A         (kbus.A),
    .B         (kbus.B),
    .C         (kbus.C)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  exp_t  exp_q[$];
  logic [3:0] hist [3];
  string legend = "123A456B789CE0FD";

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [3:0] code_of(input int k);
    byte ch;
    ch = legend[k];
    return (ch >= "A") ? 4'(ch - "A" + 10) : 4'(ch - "0");
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) hist[i] = 4'hF;
  endtask

  task automatic predict_accept(input int k);
    exp_t e;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = code_of(k);
    e.code = hist[0]; e.a = hist[0]; e.b = hist[1]; e.c = hist[2];
    exp_q.push_back(e);
  endtask

  // Monitor: every key_valid pulse must match the oldest pending expectation.
  logic prev_valid = 1'b0;
  exp_t got;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (kbus.key_valid) begin
        check("pulse_width_prev", int'(prev_valid), 0);
        check("key_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          check("key_code", int'(kbus.key_code), int'(got.code));
          check("digit_A", int'(kbus.A), int'(got.a));
          check("digit_B", int'(kbus.B), int'(got.b));
          check("digit_C", int'(kbus.C), int'(got.c));
        end
      end
      prev_valid = kbus.key_valid;
    end
  end

  task automatic press(input int k, input int hold, input int gap, input bit expect_key);
    @(posedge clk); #1;
    if (expect_key) predict_accept(k);
    pressed = 16'(1 << k);
    repeat (hold) @(posedge clk);
    #1 pressed = 16'h0;
    repeat (gap) @(posedge clk);
    check("pending_after_release", exp_q.size(), 0);
  endtask

  task automatic wait_col(input logic [3:0] target, input string name);
    int n;
    n = 0;
    while (kbus.col !== target && n < 64) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(kbus.col), int'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"},       int'(kbus.col), 4'b1110);
    check({tag, "_key_code"},  int'(kbus.key_code), 0);
    check({tag, "_key_valid"}, int'(kbus.key_valid), 0);
    check({tag, "_A"}, int'(kbus.A), 4'hF);
    check({tag, "_B"}, int'(kbus.B), 4'hF);
    check({tag, "_C"}, int'(kbus.C), 4'hF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] cols [40];
    int first_step, changes, k, c;
    logic [3:0] last_col;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Idle: column walks one step every SCAN_DIV clocks.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cols[i] = kbus.col;
    end
    first_step = 40;
    for (int i = 39; i >= 0; i--) if (cols[i] != 4'b1110) first_step = i;
    check("idle_first_step", first_step, SCAN_DIV - 1);
    for (int i = first_step; i < 40; i++)
      check("idle_col", int'(cols[i]), 15 ^ (1 << ((1 + (i - first_step) / SCAN_DIV) % 4)));
    check("idle_A", int'(kbus.A), 4'hF);

    // Key 6 (row 1, column 2), then 1, 2, 3.
    press(6, 60, 40, 1'b1);
    press(0, 60, 40, 1'b1);
    press(1, 60, 40, 1'b1);
    press(2, 60, 40, 1'b1);

    // Bounce on column 0: never DEB consecutive matching samples.
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      #1 pressed = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      repeat (SCAN_DIV) @(posedge clk);
    end
    #1 pressed = 16'h0;
    @(negedge clk);
    last_col = kbus.col;
    changes  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kbus.col != last_col) changes++;
      last_col = kbus.col;
    end
    check("bounce_resumes_scan", int'(changes >= 5), 1);
    check("bounce_no_key", exp_q.size(), 0);

    // Two keys in one column: ghost, scanning must continue.
    c = $urandom_range(0, 3);
    @(posedge clk); #1 pressed = 16'((1 << c) | (1 << (4 + c)));
    @(negedge clk);
    last_col = kbus.col;
    changes  = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (kbus.col != last_col) changes++;
      last_col = kbus.col;
    end
    #1 pressed = 16'h0;
    check("ghost_keeps_scanning", int'(changes >= 12), 1);

    // Random presses interleaved with short glitches that must be ignored.
    for (int n = 0; n < 10; n++) begin
      k = $urandom_range(0, 15);
      press(k, $urandom_range(60, 90), 40, 1'b1);
      if ($urandom_range(0, 1) == 1)
        press($urandom_range(0, 15), $urandom_range(1, 8), 30, 1'b0);
    end

    // Reset during press debounce of key 9 (row 2, column 2).
    wait_col(4'b1101, "reach_col1");
    #1 pressed = 16'h0400;
    wait_col(4'b1011, "reach_col2");
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("midreset");
    pressed = 16'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_col0", int'(kbus.col), 4'b1110);
    repeat (40) @(negedge clk);
    check("post_reset_A", int'(kbus.A), 4'hF);

    press(9, 60, 40, 1'b1);
    check("final_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles per column step (scan tick period); legal 4..65535.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4: consecutive matching scan samples needed to accept a press or release; legal 2..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port row, input, 4 bits: keypad rows, active-low, asynchronous to clk.
REQ-006 SHALL have port col, output, 4 bits: keypad column drive, active-low, one-cold.
REQ-007 SHALL have port key_code, output, 4 bits: code of the last accepted key.
REQ-008 SHALL have port key_valid, output, 1 bit: one-clk pulse per accepted press.
REQ-009 SHALL have ports A, B, C, output, 4 bits each: digit buffer for the multiplexed display; A is newest, C is oldest.

Function
REQ-010 SHALL pass row through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 SHALL run a prescaler that asserts scan_tick for one clk every SCAN_DIV clks, wrapping from SCAN_DIV-1 to 0.
REQ-012 SHALL drive col one-cold in sequence 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing only on scan_tick while in state SCAN.
REQ-013 SHALL sample synchronized rows on scan_tick, before the column advances on that edge.
REQ-014 SHALL treat a sample as a hit only when exactly one row bit is low; zero or multiple low bits count as no-key (ghost rejection).
REQ-015 SHALL map (row r, col c), r,c = 0..3, to codes: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E(*),0,F(#),D.
REQ-016 SHALL implement FSM states SCAN, DEB_PRESS, HELD, DEB_RELEASE.
REQ-017 SCAN: on a hit, SHALL latch the candidate code, freeze col, set the debounce counter to 1, and go to DEB_PRESS.
REQ-018 DEB_PRESS: on each scan_tick with the same hit, SHALL increment the counter; at DEBOUNCE_CNT SHALL go to HELD.
REQ-019 DEB_PRESS: on a different hit or no-key, SHALL return to SCAN with col unchanged; scanning resumes on the next tick.
REQ-020 On entry to HELD, SHALL on the same edge update key_code, pulse key_valid, and shift the buffer: C<=B, B<=A, A<=code.
REQ-021 HELD: col SHALL stay frozen; on a no-key sample SHALL go to DEB_RELEASE with the counter at 1; a held key SHALL never repeat.
REQ-022 DEB_RELEASE: DEBOUNCE_CNT consecutive no-key samples SHALL advance col and go to SCAN; any hit SHALL return to HELD with no new key_valid.
REQ-023 key_valid SHALL be high for exactly one clk per accepted press; the minimum spacing between pulses is 2*DEBOUNCE_CNT scan ticks.

Reset
REQ-024 While rst_n is low, SHALL hold: col=1110, key_code=0, key_valid=0, A=B=C=4'hF (blank code), FSM=SCAN, prescaler=0, debounce counter=0, synchronizer=4'hF.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL abandon the pending key with no key_valid; after release the block scans from column 0.

Structure
REQ-026 SHALL place FSM state encodings, the 16-entry key-code table, and the blank code 4'hF as constants in shared package keypad_pkg.
REQ-027 SHALL instantiate one sub-module, keypad_debounce, holding the counter and compare logic for REQ-018, REQ-019 and REQ-022.
REQ-028 Outputs A, B and C SHALL connect directly to the display block's digit inputs with no glue logic.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-029 Reset then idle rows=1111 for 40 clks -> col cycles 1110,1101,1011,0111 every 4 clks; key_valid never asserted; A=B=C=F.
REQ-030 Hold row=1101 while col=1011 for 5 ticks, then release -> exactly one key_valid, key_code=6, A=6, B=F, C=F; col resumes after 3 no-key ticks.
REQ-031 Press 1, 2, 3 in sequence (each key held and released) -> A=3, B=2, C=1, three key_valid pulses.
REQ-032 Bounce row 1110/1111 alternating each tick for 6 ticks on col 0 -> no key_valid; FSM returns to SCAN.
REQ-033 row=1100 (two keys in one column) -> no hit, no key_valid; col keeps scanning.
REQ-034 Assert rst_n low during DEB_PRESS for key 9 -> no key_valid; all outputs at their REQ-024 reset values.
